keyboard_events: RTL and testbench
==================================

Name: keyboard_events

Overview:
- Successor to the single-character keyboard front end.
- Consumes PS/2 scan-code bytes and emits full key events (make and break) through a parametrised FIFO. Each event carries the extended flag and live modifier/lock state.
- Drives the keyboard LEDs through the command channel, with a keyboard-ACK timeout and bounded retries.
- Sits between the PS/2 receiver/transmitter and the terminal input logic.

Parameters:
- FIFO_DEPTH, 4, event queue entries; power of two, ≥2.
- ACK_TIMEOUT, 16'd50000, clk cycles to wait for keyboard 0xFA after each command byte.
- RETRY_LIMIT, 2, re-sends of a whole LED sequence before abandoning it.

Ports:
- clk  in  1  system clock.
- reset_low  in  1  synchronous, active-low reset; one clock, sampled on posedge clk.
- command_ready  in  1  transmitter accepts command byte.
- command_valid  out  1  command byte offered.
- command_byte  out  8  byte to keyboard.
- command_ack_ready  out  1  waiting for transmit-complete.
- command_ack_valid  in  1  transmit complete.
- command_ack_error  in  1  transmit failed; qualified by command_ack_valid.
- scan_code_ready  out  1  byte accepted; high whenever not in reset.
- scan_code_valid  in  1  received byte present.
- scan_code_byte  in  8  received byte.
- event_ready  in  1  consumer takes event.
- event_valid  out  1  FIFO non-empty.
- event_code  out  8  scan code, prefixes stripped.
- event_extended  out  1  code was E0-prefixed.
- event_released  out  1  code was F0-prefixed (break).
- event_modifiers  out  5  {num_lock, caps_lock, alt, ctrl, shift}, sampled at enqueue.
- event_overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full.
- leds  out  3  {caps, num, scroll} state last successfully sent.

Behaviour:
- Reset values:
  - All outputs 0, except scan_code_ready=1 from the first cycle after reset.
  - FIFO empty; prefix flags, modifiers, locks, retry count and timer all 0; state IDLE.
- Prefix decode:
  - E0 sets extended; F0 sets released.
  - Any other byte completes a code and clears both flags the next cycle.
  - F0 after E0 keeps extended.
- Consumed bytes, never enqueued; they do not disturb the prefix flags:
  - 0xFA: sets ack_seen flag.
  - 0xFE: sets resend flag.
  - 0xAA: BAT; requests an LED refresh.
- Modifiers, tracked on make/break regardless of FIFO space:
  - shift = 12 or 59 held.
  - ctrl = 14 or E0 14.
  - alt = 11 or E0 11.
  - Left and right keys are tracked separately and ORed.
- Locks:
  - Non-extended make of 58 toggles caps; 77 toggles num. Break or repeat-make does not re-toggle: an internal held bit is cleared on break.
  - A toggle sets led_pending.
- Enqueue: a completed code enqueues in the same cycle. Modifiers reflect state before that code's own update.
- Full FIFO: the event is dropped and event_overflow pulses. Tracking still updates.
- Simultaneous enqueue and dequeue when full is allowed; count is unchanged.
- Output handshake:
  - event_* are stable while valid && !ready.
  - First-word latency is 1 cycle from scan-code acceptance to event_valid.
- LED FSM states: IDLE → SEND0 (0xED) → TXACK0 → KBACK0 → SEND1 (LED byte) → TXACK1 → KBACK1 → IDLE.
  - IDLE exits when led_pending; this clears led_pending and loads retry=0.
  - SENDx holds command_valid until command_ready.
  - TXACKx asserts command_ack_ready; exits on command_ack_valid.
  - KBACKx waits for ack_seen and clears it; the timer restarts on entry.
  - LED byte = {5'b0, caps, num, scroll}, sampled in the SEND1 cycle.
- Failure: command_ack_error, resend flag, or timer reaching ACK_TIMEOUT.
  - If retry<RETRY_LIMIT: retry++ and go to SEND0.
  - Otherwise go to IDLE without updating leds.
- Success: on leaving KBACK1, leds ← sent byte[2:0].
- A lock toggle during a sequence sets led_pending again, so one further sequence follows.
- Stale ack_seen and resend flags are cleared on entry to SEND0.
- Reset mid-sequence: the FSM returns to IDLE; command_valid and command_ack_ready drop the next cycle; nothing is retransmitted.

Optional Feature:
- KEYBOARD_SCROLL_LOCK_EN defined:
  - Non-extended make of 7E toggles scroll and requests an LED update.
  - 7E is still enqueued.
  - LED bit0 = scroll.
- Not defined: scroll is constant 0; 7E is an ordinary code.

Decomposition:
- keyboard_pkg holds:
  - scan-code constants (FA, FE, AA, E0, F0, 58, 77, 7E, 12, 59, 14, 11);
  - COMMAND_SET_LEDS;
  - LED FSM state enum;
  - modifier bit-index constants;
  - the event struct {code, extended, released, modifiers}.
- One sub-module, keyboard_event_fifo: a synchronous FIFO parametrised by depth and width, with push/pop, full/empty and a one-cycle-latency show-ahead output.

Test Plan:
- Sequence E0 F0 74 with event_ready=1 → one event: code=74, extended=1, released=1, modifiers=0; scan_code_ready stays 1 throughout.
- Sequence 12, 1C, F0 1C, F0 12 → events: 12 (mods=00000), 1C (shift=1), 1C released (shift=1), 12 released (shift=1).
- Make 58, keyboard answers FA after each command byte → command bytes ED then 04; leds=3'b100; only the 58 make is enqueued.
- Make 77, then no FA with ACK_TIMEOUT=20 and RETRY_LIMIT=1 → ED sent twice, FSM returns to IDLE, leds unchanged.
- event_ready=0, FIFO_DEPTH=4, five makes → four events held, event_overflow pulses once; draining yields the first four in order.
- Reset asserted in TXACK1 → next cycle: state IDLE, command_valid=0, FIFO empty, leds=0.

Source files
------------

// File: rtl/keyboard_pkg.sv
// keyboard_pkg: scan-code constants, LED FSM states and the key event
// record shared by the keyboard event front end.
package keyboard_pkg;

   localparam logic [7:0] SC_ACK    = 8'hFA;
   localparam logic [7:0] SC_RESEND = 8'hFE;
   localparam logic [7:0] SC_BAT    = 8'hAA;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_CAPS   = 8'h58;
   localparam logic [7:0] SC_NUM    = 8'h77;
   localparam logic [7:0] SC_SCROLL = 8'h7E;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_ALT    = 8'h11;

   localparam logic [7:0] COMMAND_SET_LEDS = 8'hED;

   localparam int MOD_SHIFT = 0;
   localparam int MOD_CTRL  = 1;
   localparam int MOD_ALT   = 2;
   localparam int MOD_CAPS  = 3;
   localparam int MOD_NUM   = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND0,
      ST_TXACK0,
      ST_KBACK0,
      ST_SEND1,
      ST_TXACK1,
      ST_KBACK1
   } led_state_t;

   typedef struct packed {
      logic [7:0] code;
      logic       extended;
      logic       released;
      logic [4:0] modifiers;
   } key_event_t;

endpackage

// File: rtl/keyboard_event_fifo.sv
// keyboard_event_fifo: synchronous show-ahead FIFO; head word is
// visible one cycle after the push that fills an empty queue.
module keyboard_event_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_low,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_cnt;
   logic             w_push;
   logic             w_pop;

   assign w_pop  = pop && !empty;
   assign w_push = push && (!full || w_pop);
   assign full   = (r_cnt == (AW+1)'(DEPTH));
   assign empty  = (r_cnt == '0);
   assign dout   = r_mem[r_rd];

   // Storage, pointers and occupancy; a push into a full queue is
   // accepted only when the head is leaving in the same cycle
   always_ff @(posedge clk) begin
      if (!reset_low) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= din;
            r_wr        <= r_wr + 1'b1;
         end
         if (w_pop) r_rd <= r_rd + 1'b1;
         r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end

endmodule

// File: rtl/keyboard_events.sv
// keyboard_events: PS/2 scan codes to key events plus LED command FSM.
// Optional scroll lock on code 7E: define KEYBOARD_SCROLL_LOCK_EN.
module keyboard_events
   import keyboard_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter logic [15:0] ACK_TIMEOUT = 16'd50000,
   parameter int unsigned RETRY_LIMIT = 2
) (
   input  logic       clk,
   input  logic       reset_low,
   input  logic       command_ready,
   output logic       command_valid,
   output logic [7:0] command_byte,
   output logic       command_ack_ready,
   input  logic       command_ack_valid,
   input  logic       command_ack_error,
   output logic       scan_code_ready,
   input  logic       scan_code_valid,
   input  logic [7:0] scan_code_byte,
   input  logic       event_ready,
   output logic       event_valid,
   output logic [7:0] event_code,
   output logic       event_extended,
   output logic       event_released,
   output logic [4:0] event_modifiers,
   output logic       event_overflow,
   output logic [2:0] leds
);

   localparam logic [7:0] RL = 8'(RETRY_LIMIT);

   logic        r_scan_ready, r_ext, r_rel, r_overflow;
   logic        r_lsh, r_rsh, r_lctl, r_rctl, r_lalt, r_ralt;
   logic        r_caps, r_num, r_caps_held, r_num_held;
   logic        r_ack_seen, r_resend, r_led_pending;
   led_state_t  r_state, w_next;
   logic [7:0]  r_retry;
   logic [15:0] r_timer;
   logic [2:0]  r_sent, r_leds;

   logic        w_acc, w_code, w_is_ack, w_is_resend, w_is_bat;
   logic        w_is_ext, w_is_brk, w_nx_make, w_nx_key;
   logic        w_caps_tgl, w_num_tgl, w_scroll_tgl, w_scroll;
   logic        w_led_req, w_full, w_empty, w_pop;
   logic [4:0]  w_mods;
   logic [2:0]  w_led_bits;
   key_event_t  w_evt, w_head;
   logic        w_start, w_fail, w_ok, w_ack_clr;
   logic        w_enter_send0, w_enter_kb, w_in_kb;

   assign w_acc       = scan_code_valid && r_scan_ready;
   assign w_is_ack    = w_acc && (scan_code_byte == SC_ACK);
   assign w_is_resend = w_acc && (scan_code_byte == SC_RESEND);
   assign w_is_bat    = w_acc && (scan_code_byte == SC_BAT);
   assign w_is_ext    = w_acc && (scan_code_byte == SC_EXT);
   assign w_is_brk    = w_acc && (scan_code_byte == SC_BREAK);
   assign w_code      = w_acc && !(w_is_ack || w_is_resend ||
                        w_is_bat || w_is_ext || w_is_brk);
   assign w_nx_key    = w_code && !r_ext;
   assign w_nx_make   = w_nx_key && !r_rel;
   assign w_caps_tgl  = w_nx_make && (scan_code_byte == SC_CAPS)
                        && !r_caps_held;
   assign w_num_tgl   = w_nx_make && (scan_code_byte == SC_NUM)
                        && !r_num_held;
   assign w_led_req   = w_is_bat || w_caps_tgl || w_num_tgl
                        || w_scroll_tgl;

`ifdef KEYBOARD_SCROLL_LOCK_EN
   logic r_scroll, r_scroll_held;
   assign w_scroll_tgl = w_nx_make && (scan_code_byte == SC_SCROLL)
                         && !r_scroll_held;
   assign w_scroll     = r_scroll;
   // Scroll lock toggles once per press; held bit blocks auto-repeat
   always_ff @(posedge clk) begin
      if (!reset_low) begin
         r_scroll      <= 1'b0;
         r_scroll_held <= 1'b0;
      end else begin
         if (w_scroll_tgl) r_scroll <= !r_scroll;
         if (w_nx_key && (scan_code_byte == SC_SCROLL))
            r_scroll_held <= !r_rel;
      end
   end
`else
   assign w_scroll_tgl = 1'b0;
   assign w_scroll     = 1'b0;
`endif

   always_comb begin
      w_mods            = '0;
      w_mods[MOD_SHIFT] = r_lsh || r_rsh;
      w_mods[MOD_CTRL]  = r_lctl || r_rctl;
      w_mods[MOD_ALT]   = r_lalt || r_ralt;
      w_mods[MOD_CAPS]  = r_caps;
      w_mods[MOD_NUM]   = r_num;
   end

   assign w_evt.code      = scan_code_byte;
   assign w_evt.extended  = r_ext;
   assign w_evt.released  = r_rel;
   assign w_evt.modifiers = w_mods;
   assign w_pop           = event_ready && !w_empty;

   keyboard_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(key_event_t))
   ) u_fifo (
      .clk       (clk),
      .reset_low (reset_low),
      .push      (w_code),
      .din       (w_evt),
      .pop       (w_pop),
      .dout      (w_head),
      .full      (w_full),
      .empty     (w_empty)
   );

   assign scan_code_ready = r_scan_ready;
   assign event_valid     = !w_empty;
   assign event_code      = w_head.code;
   assign event_extended  = w_head.extended;
   assign event_released  = w_head.released;
   assign event_modifiers = w_head.modifiers;
   assign event_overflow  = r_overflow;
   assign leds            = r_leds;

   // Prefix flags, modifier/lock tracking and overflow pulse
   always_ff @(posedge clk) begin
      if (!reset_low) begin
         r_scan_ready <= 1'b0;
         r_ext        <= 1'b0;
         r_rel        <= 1'b0;
         r_overflow   <= 1'b0;
         r_lsh        <= 1'b0;
         r_rsh        <= 1'b0;
         r_lctl       <= 1'b0;
         r_rctl       <= 1'b0;
         r_lalt       <= 1'b0;
         r_ralt       <= 1'b0;
         r_caps       <= 1'b0;
         r_num        <= 1'b0;
         r_caps_held  <= 1'b0;
         r_num_held   <= 1'b0;
      end else begin
         r_scan_ready <= 1'b1;
         r_overflow   <= w_code && w_full && !event_ready;
         if (w_is_ext) r_ext <= 1'b1;
         if (w_is_brk) r_rel <= 1'b1;
         if (w_code) begin
            r_ext <= 1'b0;
            r_rel <= 1'b0;
         end
         if (w_code && (scan_code_byte == SC_LSHIFT)) r_lsh <= !r_rel;
         if (w_code && (scan_code_byte == SC_RSHIFT)) r_rsh <= !r_rel;
         if (w_code && (scan_code_byte == SC_CTRL)) begin
            if (r_ext) r_rctl <= !r_rel;
            else       r_lctl <= !r_rel;
         end
         if (w_code && (scan_code_byte == SC_ALT)) begin
            if (r_ext) r_ralt <= !r_rel;
            else       r_lalt <= !r_rel;
         end
         if (w_nx_key && (scan_code_byte == SC_CAPS))
            r_caps_held <= !r_rel;
         if (w_nx_key && (scan_code_byte == SC_NUM))
            r_num_held <= !r_rel;
         if (w_caps_tgl) r_caps <= !r_caps;
         if (w_num_tgl)  r_num  <= !r_num;
      end
   end

   assign w_led_bits = {r_caps, r_num, w_scroll};
   assign w_in_kb    = (r_state == ST_KBACK0) || (r_state == ST_KBACK1);

   // LED FSM next state, strobes and command channel outputs
   always_comb begin
      w_next            = r_state;
      w_start           = 1'b0;
      w_fail            = 1'b0;
      w_ok              = 1'b0;
      w_ack_clr         = 1'b0;
      command_valid     = 1'b0;
      command_byte      = 8'h00;
      command_ack_ready = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (r_led_pending) begin
               w_next  = ST_SEND0;
               w_start = 1'b1;
            end
         end
         ST_SEND0: begin
            command_valid = 1'b1;
            command_byte  = COMMAND_SET_LEDS;
            if (command_ready) w_next = ST_TXACK0;
         end
         ST_TXACK0, ST_TXACK1: begin
            command_ack_ready = 1'b1;
            if (command_ack_valid) begin
               if (command_ack_error) w_fail = 1'b1;
               else if (r_state == ST_TXACK0) w_next = ST_KBACK0;
               else w_next = ST_KBACK1;
            end
         end
         ST_KBACK0, ST_KBACK1: begin
            if (r_resend || (r_timer == ACK_TIMEOUT)) begin
               w_fail = 1'b1;
            end else if (r_ack_seen) begin
               w_ack_clr = 1'b1;
               if (r_state == ST_KBACK0) begin
                  w_next = ST_SEND1;
               end else begin
                  w_next = ST_IDLE;
                  w_ok   = 1'b1;
               end
            end
         end
         ST_SEND1: begin
            command_valid = 1'b1;
            command_byte  = {5'b0, w_led_bits};
            if (command_ready) w_next = ST_TXACK1;
         end
         default: w_next = ST_IDLE;
      endcase
      if (w_fail) w_next = (r_retry < RL) ? ST_SEND0 : ST_IDLE;
   end

   assign w_enter_send0 = (w_next == ST_SEND0) && (r_state != ST_SEND0);
   assign w_enter_kb    = ((w_next == ST_KBACK0) || (w_next == ST_KBACK1))
                          && !w_in_kb;

   // LED FSM state, retry/timer and keyboard reply flags
   always_ff @(posedge clk) begin
      if (!reset_low) begin
         r_state       <= ST_IDLE;
         r_retry       <= '0;
         r_timer       <= '0;
         r_sent        <= '0;
         r_leds        <= '0;
         r_ack_seen    <= 1'b0;
         r_resend      <= 1'b0;
         r_led_pending <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_start) r_retry <= '0;
         else if (w_fail && (r_retry < RL)) r_retry <= r_retry + 8'd1;
         if (w_enter_kb) r_timer <= '0;
         else if (w_in_kb) r_timer <= r_timer + 16'd1;
         if ((r_state == ST_SEND1) && command_ready) r_sent <= w_led_bits;
         if (w_ok) r_leds <= r_sent;
         if (w_enter_send0) r_ack_seen <= 1'b0;
         else if (w_is_ack) r_ack_seen <= 1'b1;
         else if (w_ack_clr) r_ack_seen <= 1'b0;
         if (w_enter_send0) r_resend <= 1'b0;
         else if (w_is_resend) r_resend <= 1'b1;
         if (w_led_req) r_led_pending <= 1'b1;
         else if (w_start) r_led_pending <= 1'b0;
      end
   end

endmodule

// File: tb/tb_keyboard_events.sv
// tb_keyboard_events: scoreboard bench for keyboard_events with a
// small keyboard/transmitter responder for the LED command channel.
module tb_keyboard_events;
   import keyboard_pkg::*;

   logic       clk = 1'b0;
   logic       reset_low;
   logic       command_ready, command_valid;
   logic [7:0] command_byte;
   logic       command_ack_ready, command_ack_valid, command_ack_error;
   logic       scan_code_ready, scan_code_valid;
   logic [7:0] scan_code_byte;
   logic       event_ready, event_valid;
   logic [7:0] event_code;
   logic       event_extended, event_released;
   logic [4:0] event_modifiers;
   logic       event_overflow;
   logic [2:0] leds;

   int n_chk  = 0;
   int n_pass = 0;
   int n_ovf  = 0;
   key_event_t exp_q[$];

   always #5 clk = ~clk;

   keyboard_events #(
      .FIFO_DEPTH  (4),
      .ACK_TIMEOUT (16'd20),
      .RETRY_LIMIT (1)
   ) dut (
      .clk               (clk),
      .reset_low         (reset_low),
      .command_ready     (command_ready),
      .command_valid     (command_valid),
      .command_byte      (command_byte),
      .command_ack_ready (command_ack_ready),
      .command_ack_valid (command_ack_valid),
      .command_ack_error (command_ack_error),
      .scan_code_ready   (scan_code_ready),
      .scan_code_valid   (scan_code_valid),
      .scan_code_byte    (scan_code_byte),
      .event_ready       (event_ready),
      .event_valid       (event_valid),
      .event_code        (event_code),
      .event_extended    (event_extended),
      .event_released    (event_released),
      .event_modifiers   (event_modifiers),
      .event_overflow    (event_overflow),
      .leds              (leds)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic key_event_t ev(input logic [7:0] c, input logic e,
                                     input logic r, input logic [4:0] m);
      key_event_t k;
      k.code      = c;
      k.extended  = e;
      k.released  = r;
      k.modifiers = m;
      return k;
   endfunction

   // Scoreboard: every handshaken event is popped and compared
   always @(negedge clk) begin
      key_event_t e;
      if (reset_low === 1'b1 && event_valid && event_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexp_evt", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            chk("evt", 32'({event_code, event_extended,
                            event_released, event_modifiers}), 32'(e));
         end
      end
      if (event_overflow === 1'b1) n_ovf++;
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      @(posedge clk);
      #1;
      chk("scan_rdy", 32'(scan_code_ready), 32'd1);
      scan_code_valid = 1'b1;
      scan_code_byte  = b;
      @(posedge clk);
      #1;
      scan_code_valid = 1'b0;
   endtask

   // mode 0: tx ack, no keyboard reply; 1: tx ack then FA;
   // 2: stop in the tx-ack wait
   task automatic kb_cmd(input logic [7:0] b, input int mode);
      int n = 0;
      while (!command_valid && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("cmd_wait", 32'(command_valid), 32'd1);
      if (command_valid) begin
         chk("cmd_byte", 32'(command_byte), 32'(b));
         command_ready = 1'b1;
         @(posedge clk);
         #1;
         command_ready = 1'b0;
         chk("ack_rdy", 32'(command_ack_ready), 32'd1);
         if (mode != 2) begin
            command_ack_valid = 1'b1;
            @(posedge clk);
            #1;
            command_ack_valid = 1'b0;
            if (mode == 1) send(SC_ACK);
         end
      end
   endtask

   task automatic watch_quiet(input string tag, input int n);
      int seen = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (command_valid) seen++;
      end
      chk(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_low         = 1'b0;
      command_ready     = 1'b0;
      command_ack_valid = 1'b0;
      command_ack_error = 1'b0;
      scan_code_valid   = 1'b0;
      scan_code_byte    = 8'h00;
      event_ready       = 1'b1;

      cycles(3);
      chk("rst_evalid", 32'(event_valid), 32'd0);
      chk("rst_cvalid", 32'(command_valid), 32'd0);
      chk("rst_ackrdy", 32'(command_ack_ready), 32'd0);
      chk("rst_leds", 32'(leds), 32'd0);
      chk("rst_ovf", 32'(event_overflow), 32'd0);
      chk("rst_srdy", 32'(scan_code_ready), 32'd0);
      reset_low = 1'b1;
      cycles(1);
      chk("srdy_after", 32'(scan_code_ready), 32'd1);

      // Extended break with both prefixes
      exp_q.push_back(ev(8'h74, 1'b1, 1'b1, 5'b00000));
      send(SC_EXT);
      send(SC_BREAK);
      send(8'h74);
      chk("latency", 32'(event_valid), 32'd1);
      cycles(3);

      // Shift tracking, modifiers sampled before own update
      exp_q.push_back(ev(8'h12, 1'b0, 1'b0, 5'b00000));
      send(8'h12);
      exp_q.push_back(ev(8'h1C, 1'b0, 1'b0, 5'b00001));
      send(8'h1C);
      exp_q.push_back(ev(8'h1C, 1'b0, 1'b1, 5'b00001));
      send(SC_BREAK);
      send(8'h1C);
      exp_q.push_back(ev(8'h12, 1'b0, 1'b1, 5'b00001));
      send(SC_BREAK);
      send(8'h12);
      cycles(3);
      chk("q_mod", 32'(exp_q.size()), 32'd0);

      // Caps lock: successful LED sequence
      exp_q.push_back(ev(SC_CAPS, 1'b0, 1'b0, 5'b00000));
      send(SC_CAPS);
      kb_cmd(COMMAND_SET_LEDS, 1);
      kb_cmd(8'h04, 1);
      cycles(5);
      chk("leds_caps", 32'(leds), 32'd4);
      exp_q.push_back(ev(8'h1C, 1'b0, 1'b0, 5'b01000));
      send(8'h1C);
      exp_q.push_back(ev(SC_CAPS, 1'b0, 1'b1, 5'b01000));
      send(SC_BREAK);
      send(SC_CAPS);
      watch_quiet("brk_no_cmd", 10);

      // Num lock: keyboard never answers, one retry then give up
      exp_q.push_back(ev(SC_NUM, 1'b0, 1'b0, 5'b01000));
      send(SC_NUM);
      kb_cmd(COMMAND_SET_LEDS, 0);
      kb_cmd(COMMAND_SET_LEDS, 0);
      watch_quiet("no_3rd_try", 40);
      chk("leds_kept", 32'(leds), 32'd4);

      // Overflow with consumer stalled
      event_ready = 1'b0;
      n_ovf = 0;
      exp_q.push_back(ev(8'h1C, 1'b0, 1'b0, 5'b11000));
      exp_q.push_back(ev(8'h32, 1'b0, 1'b0, 5'b11000));
      exp_q.push_back(ev(8'h21, 1'b0, 1'b0, 5'b11000));
      exp_q.push_back(ev(8'h23, 1'b0, 1'b0, 5'b11000));
      send(8'h1C);
      send(8'h32);
      send(8'h21);
      send(8'h23);
      send(8'h24);
      cycles(3);
      chk("ovf_pulses", 32'(n_ovf), 32'd1);
      chk("hold_valid", 32'(event_valid), 32'd1);
      chk("hold_code", 32'(event_code), 32'h1C);
      event_ready = 1'b1;
      cycles(8);
      chk("q_drain", 32'(exp_q.size()), 32'd0);
      chk("drained", 32'(event_valid), 32'd0);

      // Reset while waiting for transmit-complete of the LED byte
      exp_q.push_back(ev(SC_CAPS, 1'b0, 1'b0, 5'b11000));
      send(SC_CAPS);
      kb_cmd(COMMAND_SET_LEDS, 1);
      kb_cmd(8'h02, 2);
      chk("q_pre_rst", 32'(exp_q.size()), 32'd0);
      chk("leds_pre_rst", 32'(leds), 32'd4);
      reset_low = 1'b0;
      cycles(1);
      chk("mid_cvalid", 32'(command_valid), 32'd0);
      chk("mid_ackrdy", 32'(command_ack_ready), 32'd0);
      chk("mid_evalid", 32'(event_valid), 32'd0);
      chk("mid_leds", 32'(leds), 32'd0);
      reset_low = 1'b1;
      watch_quiet("no_resend", 30);

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
